exec_unit_mc: RTL

Parametrised execute stage for the 5-stage pipeline. It generalises the combinational execute logic to a configurable datapath width and adds a registered output stage. It also adds an iterative shift-add multiplier that stalls the decode stage through a ready/valid handshake. It sits between the ID/EX register and EX/MEM: it resolves operand forwarding from MEM and WB, computes the ALU result or branch decision, and presents a registered result to the memory stage.

---
 rtl/exec_unit_mc.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: parametrised execute stage with a registered result and an
// iterative shift-add multiplier.
//
// Resolves operand forwarding from MEM and WB, computes the ALU result and
// the branch decision, and registers everything for the memory stage. MUL
// (op 8) runs for XLEN cycles in the MUL state and stalls decode meanwhile.
//
// Handshake: an instruction is taken on a rising edge where
// in_valid && in_ready && !flush. in_ready is high exactly while the FSM is
// IDLE; upstream holds the instruction while in_ready is low. out_valid is a
// one-cycle pulse per completed instruction; there is no output backpressure.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake
//   flush                     kill in-flight MUL and block acceptance
//   op, use_imm               operation select, operand B = imm
//   rs, rt, rd                register numbers
//   rs_data, rt_data          register-file values
//   imm, pc                   sign-extended immediate, instruction PC
//   we                        instruction writes rd
//   br_en, br_ne              branch enable, 0 = BEQ / 1 = BNE
//   mem_we/mem_rd/mem_data    EX/MEM forwarding source
//   wb_we/wb_rd/wb_data       MEM/WB forwarding source
//   out_valid, out_data, out_rd, out_we, br_taken, br_target   registered result
module exec_unit_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [3:0]      op,
  input  logic            use_imm,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            we,
  input  logic            br_en,
  input  logic            br_ne,
  input  logic            mem_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] opb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu;
  logic            br_cond;
  logic [XLEN-1:0] tgt;
  logic            accept;
  logic            is_mul;

  // Multiplier state
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_step;
  logic [CW-1:0]   cnt;
  logic            mul_last;
  logic [4:0]      mul_rd;
  logic            mul_we;

  // Forwarding: MEM beats WB, register 0 is never forwarded.
  always_comb begin
    fwd_a = rs_data;
    if (mem_we && (mem_rd == rs) && (rs != 5'd0)) begin
      fwd_a = mem_data;
    end else if (wb_we && (wb_rd == rs) && (rs != 5'd0)) begin
      fwd_a = wb_data;
    end
    fwd_b = rt_data;
    if (mem_we && (mem_rd == rt) && (rt != 5'd0)) begin
      fwd_b = mem_data;
    end else if (wb_we && (wb_rd == rt) && (rt != 5'd0)) begin
      fwd_b = wb_data;
    end
  end

  assign opb   = use_imm ? imm : fwd_b;
  assign shamt = opb[SHW-1:0];

  always_comb begin
    alu = '0;
    case (op)
      4'd0: alu = fwd_a + opb;
      4'd1: alu = fwd_a - opb;
      4'd2: alu = fwd_a & opb;
      4'd3: alu = fwd_a | opb;
      4'd4: alu = fwd_a ^ opb;
      4'd5: alu = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(opb))};
      4'd6: alu = fwd_a << shamt;
      4'd7: alu = fwd_a >> shamt;
      default: alu = '0;
    endcase
  end

  // Branch compare always uses the forwarded register values, never imm.
  assign br_cond = br_en && (br_ne ? (fwd_a != fwd_b) : (fwd_a == fwd_b));
  assign tgt     = pc + (imm << 2);

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && !flush && (state == S_IDLE);
  assign is_mul   = (op == 4'd8);

  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (cnt == CW'(XLEN - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:  if (mul_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Datapath and output registers. The valid-qualified outputs default low
  // every cycle so each result is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= 5'd0;
      out_we    <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      mul_rd    <= 5'd0;
      mul_we    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      br_taken  <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (is_mul) begin
                mcand  <= fwd_a;
                mplier <= opb;
                acc    <= '0;
                cnt    <= '0;
                mul_rd <= rd;
                mul_we <= we;
              end else begin
                out_valid <= 1'b1;
                out_data  <= alu;
                out_rd    <= rd;
                out_we    <= we;
                br_taken  <= br_cond;
                br_target <= tgt;
              end
            end
          end
          S_MUL: begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (mul_last) begin
              // Final step: publish the accumulator including this step's add.
              cnt       <= '0;
              out_valid <= 1'b1;
              out_data  <= acc_step;
              out_rd    <= mul_rd;
              out_we    <= mul_we;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule
